// File: rtl/alu_control_if.sv
// ALU control bundle: operation class and funct in,
// registered select code and decode flags out.
interface alu_control_if;
  logic [5:0] funct;
  logic [2:0] aluOP;
  logic [2:0] aluSel;
  logic       illegal_funct;
  logic       is_shift;
  logic       is_jr;

  modport master (
    output funct,
    output aluOP,
    input  aluSel,
    input  illegal_funct,
    input  is_shift,
    input  is_jr
  );

  modport slave (
    input  funct,
    input  aluOP,
    output aluSel,
    output illegal_funct,
    output is_shift,
    output is_jr
  );
endinterface

// File: rtl/alu_control.sv
// ALU control: decodes aluOP/funct into the ALU select
// code and R-type flags, registered for one cycle latency.
module alu_control (
  input  logic          clk,
  input  logic          reset,
  alu_control_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_ADD = 3'b000,
    SEL_SUB = 3'b001,
    SEL_SRL = 3'b010,
    SEL_JR  = 3'b011,
    SEL_AND = 3'b100,
    SEL_OR  = 3'b101,
    SEL_SLT = 3'b110,
    SEL_SLL = 3'b111
  } sel_t;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;

  logic r_type;
  sel_t sel_d;
  logic ill_d;
  logic shift_d;
  logic jr_d;

  assign r_type = (bus.aluOP == 3'b000);

  always_comb begin
    sel_d = SEL_ADD;
    ill_d = 1'b0;
    unique case (bus.aluOP)
      3'b000: begin
        unique case (bus.funct)
          F_ADD:   sel_d = SEL_ADD;
          F_SUB:   sel_d = SEL_SUB;
          F_SRL:   sel_d = SEL_SRL;
          F_JR:    sel_d = SEL_JR;
          F_AND:   sel_d = SEL_AND;
          F_OR:    sel_d = SEL_OR;
          F_SLT:   sel_d = SEL_SLT;
          F_SLL:   sel_d = SEL_SLL;
          default: ill_d = 1'b1;
        endcase
      end
      3'b001: sel_d = SEL_OR;
      3'b010: sel_d = SEL_ADD;
      3'b011: sel_d = SEL_ADD;
      3'b100: sel_d = SEL_SUB;
      3'b101: sel_d = SEL_JR;
      3'b110: sel_d = SEL_AND;
      3'b111: sel_d = SEL_SLT;
    endcase
  end

  // Flags only ever come from an R-type decode; funct is
  // a don't-care for every other operation class.
  assign shift_d = r_type &&
                   ((sel_d == SEL_SRL) || (sel_d == SEL_SLL));
  assign jr_d    = r_type && (bus.funct == F_JR);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.aluSel        <= SEL_ADD;
      bus.illegal_funct <= 1'b0;
      bus.is_shift      <= 1'b0;
      bus.is_jr         <= 1'b0;
    end else begin
      bus.aluSel        <= sel_d;
      bus.illegal_funct <= ill_d;
      bus.is_shift      <= shift_d;
      bus.is_jr         <= jr_d;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Bench for alu_control: table-driven reference model,
// directed plan with literal pins, then random stimulus.
module tb_alu_control;

  logic clk;
  logic reset;
  alu_control_if bus ();

  alu_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Supported R-type funct codes; position is the select code.
  logic [5:0] r_fn [0:7] = '{6'b100000, 6'b100010,
                             6'b000010, 6'b001000,
                             6'b100100, 6'b100101,
                             6'b101010, 6'b000000};
  // Select code per non-R aluOP (entry 0 unused).
  logic [2:0] ij_sel [0:7] = '{3'd0, 3'd5, 3'd0, 3'd0,
                               3'd1, 3'd3, 3'd4, 3'd6};

  // Returns {sel[2:0], illegal, shift, jr}.
  function automatic logic [5:0] ref_out(
    input logic [2:0] op,
    input logic [5:0] fn
  );
    logic [2:0] s;
    logic       ill;
    if (op != 3'b000)
      return {ij_sel[op], 3'b000};
    s   = 3'd0;
    ill = 1'b1;
    for (int i = 0; i < 8; i++)
      if (r_fn[i] == fn) begin
        s   = i[2:0];
        ill = 1'b0;
      end
    return {s, ill,
            (fn == 6'b000010) || (fn == 6'b000000),
            fn == 6'b001000};
  endfunction

  logic [5:0] exp_q;
  logic       known;
  logic       lit_en;
  logic [5:0] lit_val;
  logic       lit_en_q;
  logic [5:0] lit_q;
  string      lit_name;
  string      lit_name_q;
  int         n_cmp;
  int         n_bad;

  initial begin
    known    = 1'b0;
    lit_en_q = 1'b0;
    n_cmp    = 0;
    n_bad    = 0;
  end

  always @(posedge clk) begin
    exp_q      <= reset ? 6'd0 : ref_out(bus.aluOP, bus.funct);
    known      <= known | reset;
    lit_en_q   <= lit_en;
    lit_q      <= lit_val;
    lit_name_q <= lit_name;
  end

  logic [5:0] act;
  assign act = {bus.aluSel, bus.illegal_funct,
                bus.is_shift, bus.is_jr};

  always @(negedge clk) begin
    if (known) begin
      n_cmp = n_cmp + 1;
      if (act !== exp_q) begin
        n_bad = n_bad + 1;
        $display("FAIL model t=%0t got=%b want=%b",
                 $time, act, exp_q);
      end
      if (lit_en_q) begin
        n_cmp = n_cmp + 1;
        if (act !== lit_q || exp_q !== lit_q) begin
          n_bad = n_bad + 1;
          $display("FAIL %s got=%b model=%b want=%b",
                   lit_name_q, act, exp_q, lit_q);
        end
      end
    end
  end

  task automatic drive(
    input logic       r,
    input logic [2:0] op,
    input logic [5:0] fn
  );
    @(negedge clk);
    reset      = r;
    bus.aluOP  = op;
    bus.funct  = fn;
    lit_en     = 1'b0;
  endtask

  task automatic pin(
    input logic       r,
    input logic [2:0] op,
    input logic [5:0] fn,
    input logic [5:0] want,
    input string      name
  );
    drive(r, op, fn);
    lit_en   = 1'b1;
    lit_val  = want;
    lit_name = name;
  endtask

  initial begin
    reset     = 1'b1;
    bus.aluOP = 3'b000;
    bus.funct = 6'b100010;
    lit_en    = 1'b0;
    lit_val   = 6'd0;
    lit_name  = "";

    pin(1'b1, 3'b000, 6'b100010, 6'b000000, "rst0");
    pin(1'b1, 3'b000, 6'b100010, 6'b000000, "rst1");
    pin(1'b0, 3'b000, 6'b100010, 6'b001000, "rel");

    pin(1'b0, 3'b000, 6'b100000, 6'b000000, "r_add");
    pin(1'b0, 3'b000, 6'b100010, 6'b001000, "r_sub");
    pin(1'b0, 3'b000, 6'b000010, 6'b010010, "r_srl");
    pin(1'b0, 3'b000, 6'b001000, 6'b011001, "r_jr");
    pin(1'b0, 3'b000, 6'b100100, 6'b100000, "r_and");
    pin(1'b0, 3'b000, 6'b100101, 6'b101000, "r_or");
    pin(1'b0, 3'b000, 6'b101010, 6'b110000, "r_slt");
    pin(1'b0, 3'b000, 6'b000000, 6'b111010, "r_sll");

    pin(1'b0, 3'b000, 6'b111111, 6'b000100, "ill");
    pin(1'b0, 3'b000, 6'b100000, 6'b000000, "ill_clr");

    pin(1'b0, 3'b001, 6'b000000, 6'b101000, "ij_ori");
    pin(1'b0, 3'b010, 6'b000000, 6'b000000, "ij_addi");
    pin(1'b0, 3'b011, 6'b000000, 6'b000000, "ij_li");
    pin(1'b0, 3'b100, 6'b000000, 6'b001000, "ij_beq");
    pin(1'b0, 3'b101, 6'b000000, 6'b011000, "ij_j");
    pin(1'b0, 3'b110, 6'b000000, 6'b100000, "ij_andi");
    pin(1'b0, 3'b111, 6'b000000, 6'b110000, "ij_slti");

    pin(1'b0, 3'b100, 6'b000000, 6'b001000, "fi0");
    pin(1'b0, 3'b100, 6'b101010, 6'b001000, "fi1");
    pin(1'b0, 3'b100, 6'b111111, 6'b001000, "fi2");

    drive(1'b0, 3'b000, 6'b000010);
    drive(1'b0, 3'b000, 6'b001000);
    pin(1'b1, 3'b001, 6'b001000, 6'b000000, "mid_rst");
    pin(1'b0, 3'b001, 6'b001000, 6'b101000, "mid_rel");

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      logic [5:0] fn;
      op = $urandom_range(0, 3) == 0 ? 3'($urandom)
                                     : 3'b000;
      fn = $urandom_range(0, 1) == 0
           ? r_fn[$urandom_range(0, 7)]
           : 6'($urandom);
      drive($urandom_range(0, 19) == 0, op, fn);
    end

    drive(1'b0, 3'b000, 6'b000000);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
